// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and optional first-word-fall-through.
// Ports:
//   clk, rst             clock and synchronous active-high reset
//   wr_en, data_in       write request and write data
//   rd_en, data_out      read request and read data (registered)
//   full, empty          count == DEPTH / count == 0
//   almost_full          count >= AF_THRESH
//   almost_empty         count <= AE_THRESH
//   count                current occupancy 0..DEPTH
//   overflow, underflow  sticky rejected-write / rejected-read flags
module sync_fifo_param #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_THRESH = 14,
  parameter int unsigned AE_THRESH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        data_out,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;

  // Elaboration-time parameter checks
  if (DATA_W < 1) begin : g_bad_width
    $error("sync_fifo_param: DATA_W must be >= 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two >= 2");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("sync_fifo_param: AF_THRESH must be in 1..DEPTH");
  end
  if (AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("sync_fifo_param: AE_THRESH must be in 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              almost_full_q, almost_full_d;
  logic              almost_empty_q, almost_empty_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic              rd_acc;
  logic              wr_acc;

  // Next-state logic: accept decisions, pointers, count, flags, read data
  always_comb begin
    rd_acc         = rd_en && !empty_q;
    wr_acc         = wr_en && (!full_q || rd_acc);
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    data_out_d     = data_out_q;
    overflow_d     = overflow_q  || (wr_en && !wr_acc);
    underflow_d    = underflow_q || (rd_en && !rd_acc);

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Flags registered from next count so they never lag count
    full_d         = (count_d == CNT_W'(DEPTH));
    empty_d        = (count_d == CNT_W'(0));
    almost_full_d  = (count_d >= CNT_W'(AF_THRESH));
    almost_empty_d = (count_d <= CNT_W'(AE_THRESH));

    if (FWFT == 0) begin
      if (rd_acc) data_out_d = mem_q[rd_ptr_q];
    end else if (count_d != CNT_W'(0)) begin
      // New head is the word being written this edge when it lands at rd_ptr_d
      if (wr_acc && (wr_ptr_q == rd_ptr_d)) data_out_d = data_in;
      else                                  data_out_d = mem_q[rd_ptr_d];
    end
  end

  // Control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
      data_out_q     <= '0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
      data_out_q     <= data_out_d;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

  assign data_out     = data_out_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: one instance in registered-read mode,
// one in first-word-fall-through mode, both 8 bits x 16 entries.
module tb_sync_fifo_param;

  localparam int unsigned DW  = 8;
  localparam int unsigned DEP = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read instance signals
  logic          rst0, wr0, rd0;
  logic [DW-1:0] din0, dout0;
  logic          full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]    cnt0;

  // FWFT instance signals
  logic          rst1, wr1, rd1;
  logic [DW-1:0] din1, dout1;
  logic          full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]    cnt1;

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst0), .wr_en(wr0), .data_in(din0), .rd_en(rd0), .data_out(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_param #(.DATA_W(DW), .DEPTH(DEP), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst1), .wr_en(wr1), .data_in(din1), .rd_en(rd1), .data_out(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Vector record: inputs then expected outputs after the edge
  typedef struct {
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic [4:0]    cnt;
    logic [5:0]    flg;   // {full, empty, almost_full, almost_empty, overflow, underflow}
    logic [DW-1:0] dout;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs[NV];

  // Reference queue for the registered-read instance
  logic [DW-1:0] sb[$];

  // One cycle on dut0 with reference-model prediction and checks
  task automatic step0(input logic wr, input logic rd, input logic [DW-1:0] d, input string tag);
    logic          racc, wacc;
    logic [DW-1:0] exp_d;
    racc  = rd && (sb.size() != 0);
    wacc  = wr && ((sb.size() < DEP) || racc);
    exp_d = '0;
    if (racc) exp_d = sb.pop_front();
    if (wacc) sb.push_back(d);
    wr0 = wr; rd0 = rd; din0 = d;
    @(posedge clk); #1;
    chk({tag, "_count"}, 32'(cnt0), 32'(sb.size()));
    if (racc) chk({tag, "_data"}, 32'(dout0), 32'(exp_d));
    wr0 = 1'b0; rd0 = 1'b0;
  endtask

  task automatic reset0();
    rst0 = 1'b1; wr0 = 1'b0; rd0 = 1'b0;
    @(posedge clk); #1;
    rst0 = 1'b0;
    sb.delete();
  endtask

  initial begin
    int n;
    rst0 = 1'b1; wr0 = 1'b1; rd0 = 1'b1; din0 = 8'h99;
    rst1 = 1'b1; wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;

    // Build table: reset with both enables high, fill, overflow, drain, underflow
    n = 0;
    for (int i = 0; i < 2; i++) begin
      vecs[n] = '{1'b1, 1'b1, 1'b1, 8'h99, 5'd0, 6'b010100, 8'h00}; n++;
    end
    for (int k = 1; k <= 16; k++) begin
      vecs[n] = '{1'b0, 1'b1, 1'b0, DW'(k), 5'(k),
                  {k == 16, 1'b0, k >= 14, k <= 2, 1'b0, 1'b0}, 8'h00}; n++;
    end
    vecs[n] = '{1'b0, 1'b1, 1'b0, 8'hAA, 5'd16, 6'b101010, 8'h00}; n++;
    for (int k = 1; k <= 16; k++) begin
      vecs[n] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'(16 - k),
                  {1'b0, k == 16, (16 - k) >= 14, (16 - k) <= 2, 1'b1, 1'b0}, DW'(k)}; n++;
    end
    vecs[n] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, 6'b010111, 8'h10}; n++;

    for (int i = 0; i < NV; i++) begin
      rst0 = vecs[i].rst; wr0 = vecs[i].wr; rd0 = vecs[i].rd; din0 = vecs[i].din;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_count", i), 32'(cnt0), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_flags", i), 32'({full0, empty0, af0, ae0, ovf0, unf0}),
          32'(vecs[i].flg));
      chk($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vecs[i].dout));
    end
    rst1 = 1'b0;

    // Simultaneous write/read while full
    reset0();
    chk("sim_rst_flags", 32'({full0, empty0, ovf0, unf0}), 32'(4'b0100));
    for (int k = 1; k <= 16; k++) step0(1'b1, 1'b0, DW'(k), "sim_fill");
    chk("sim_full", 32'(full0), 32'(1));
    step0(1'b1, 1'b1, 8'h55, "sim_both");
    chk("sim_full_hold", 32'(full0), 32'(1));
    chk("sim_no_ovf", 32'(ovf0), 32'(0));
    for (int k = 0; k < 16; k++) step0(1'b0, 1'b1, 8'h00, "sim_drain");
    chk("sim_last_055", 32'(dout0), 32'h55);
    chk("sim_empty", 32'(empty0), 32'(1));

    // Wrap-around: write every cycle, read two of every three, then drain
    reset0();
    for (int i = 0; i < 40; i++)
      step0(1'b1, (i % 3) != 0, DW'($urandom_range(0, 255)), "wrap");
    while (sb.size() != 0) step0(1'b0, 1'b1, 8'h00, "wrap_drain");
    chk("wrap_empty", 32'(empty0), 32'(1));
    chk("wrap_errs", 32'({ovf0, unf0}), 32'(0));

    // First-word-fall-through instance
    chk("fwft_rst", 32'({dout1, empty1, unf1}), 32'({8'h00, 1'b1, 1'b0}));
    wr1 = 1'b1; din1 = 8'h3C;
    @(posedge clk); #1;
    wr1 = 1'b0;
    chk("fwft_head", 32'(dout1), 32'h3C);
    chk("fwft_cnt1", 32'(cnt1), 32'(1));
    @(posedge clk); #1;
    chk("fwft_hold_head", 32'(dout1), 32'h3C);
    rd1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    chk("fwft_pop_empty", 32'(empty1), 32'(1));
    chk("fwft_pop_dout", 32'(dout1), 32'h3C);
    wr1 = 1'b1; rd1 = 1'b1; din1 = 8'h7E;
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b0;
    chk("fwft_unf", 32'(unf1), 32'(1));
    chk("fwft_cnt_after", 32'(cnt1), 32'(1));
    chk("fwft_new_head", 32'(dout1), 32'h7E);
    wr1 = 1'b1; din1 = 8'hA1;
    @(posedge clk); #1;
    wr1 = 1'b0;
    chk("fwft_head_kept", 32'(dout1), 32'h7E);
    rd1 = 1'b1;
    @(posedge clk); #1;
    rd1 = 1'b0;
    chk("fwft_next_head", 32'(dout1), 32'hA1);
    chk("fwft_cnt_pop", 32'(cnt1), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
